id_exe_reg: RTL and testbench
=============================

Name: id_exe_reg

Overview:
ID/EXE pipeline register of the 5-stage MIPS core. It is the producer side of the EXE operand interface: it captures decoded control and forwarded register operands at the end of ID and presents eqb, ealuimm and esign_ex_out to the EXE-stage operand-B select. It supports bubble insertion for load-use hazards and branch flush, plus a full-freeze hold.

Parameters:
DW, 32, datapath width of operands and immediate
RW, 5, register-number width
AW, 4, ALU control width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
hold  input  1  freeze: all outputs keep value
bubble  input  1  load-use stall: insert NOP into EXE
flush  input  1  control-flow flush: insert NOP into EXE
dwreg  input  1  ID: register-file write enable
dm2reg  input  1  ID: writeback selects memory data
dwmem  input  1  ID: data-memory write enable
daluimm  input  1  ID: ALU operand B is immediate
daluc  input  AW  ID: ALU operation
drn  input  RW  ID: destination register number
dqa  input  DW  ID: register-file read port A
dqb  input  DW  ID: register-file read port B
dsign_ex_out  input  DW  ID: sign/zero-extended immediate
fwda  input  2  forward select for A: 00 dqa, 01 ealu, 10 malu, 11 mmo
fwdb  input  2  forward select for B, same encoding
ealu  input  DW  EXE ALU result (forward source)
malu  input  DW  MEM ALU result (forward source)
mmo  input  DW  MEM load data (forward source)
ewreg  output  1  EXE register write enable
em2reg  output  1  EXE mem-to-reg
ewmem  output  1  EXE memory write enable
ealuimm  output  1  EXE operand-B immediate select
ealuc  output  AW  EXE ALU operation
ern  output  RW  EXE destination register
eqa  output  DW  EXE operand A
eqb  output  DW  EXE register operand B (also store data)
esign_ex_out  output  DW  EXE immediate
evalid  output  1  EXE slot holds a real instruction

Behaviour:
- rst high (any time, asynchronously, including mid-hold or mid-bubble): all outputs 0 immediately; they remain 0 while rst is high. The first capture occurs on the first rising edge after rst falls.
- Per rising edge, priority is flush > hold > bubble > load.
- flush: ewreg, em2reg, ewmem, ealuimm, evalid = 0. ealuc, ern, eqa, eqb, esign_ex_out = 0.
- hold (flush low): every output keeps its value. Forward sources are ignored.
- bubble (flush and hold low): same as flush. It is a distinct input for coverage and debug only.
- load: all fields are captured from the ID inputs and evalid = 1.
- Load, forwarding: eqa = mux(fwda) and eqb = mux(fwdb), sampled in the same edge.
- eqb always carries the register/forwarded value, never the immediate. Immediate selection happens downstream under ealuimm.
- $0 rule: if drn == 0, ewreg is captured as 0 regardless of dwreg.
- Latency is exactly 1 cycle from ID inputs to E outputs. There is no combinational path from inputs to outputs.
- There are no X outputs after reset. All outputs are driven from flops only.

Test Plan:
- Reset: assert rst mid-cycle with outputs nonzero -> all outputs 0 before the next edge; evalid = 0.
- Load with fwd 00: dqa=0x11, dqb=0x22, dsign_ex_out=0xFFFFFFF0, daluimm=1, drn=8, dwreg=1 -> next edge eqa=0x11, eqb=0x22, esign_ex_out=0xFFFFFFF0, ealuimm=1, ern=8, ewreg=1, evalid=1.
- Forwarding: fwda=01 with ealu=0xA5, and fwdb=11 with mmo=0x5A -> eqa=0xA5, eqb=0x5A. Repeat the check for fwdb=10 with malu=0x77 -> eqb=0x77.
- Bubble: bubble=1 with dwreg=1, dwmem=1 -> ewreg=0, ewmem=0, evalid=0. The next non-bubble edge loads normally.
- Priority: hold=1 for 3 cycles while inputs change -> outputs unchanged. Then hold=1 and flush=1 together -> outputs cleared, evalid=0.
- $0 write: drn=0, dwreg=1 -> ewreg=0, ern=0, evalid=1.

Source files
------------

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded control and forwarded operands at the end of ID.
// flush > hold > bubble > load on each rising edge; rst clears everything asynchronously.
module id_exe_reg #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          bubble,
  input  logic          flush,
  input  logic          dwreg,
  input  logic          dm2reg,
  input  logic          dwmem,
  input  logic          daluimm,
  input  logic [AW-1:0] daluc,
  input  logic [RW-1:0] drn,
  input  logic [DW-1:0] dqa,
  input  logic [DW-1:0] dqb,
  input  logic [DW-1:0] dsign_ex_out,
  input  logic [1:0]    fwda,
  input  logic [1:0]    fwdb,
  input  logic [DW-1:0] ealu,
  input  logic [DW-1:0] malu,
  input  logic [DW-1:0] mmo,
  output logic          ewreg,
  output logic          em2reg,
  output logic          ewmem,
  output logic          ealuimm,
  output logic [AW-1:0] ealuc,
  output logic [RW-1:0] ern,
  output logic [DW-1:0] eqa,
  output logic [DW-1:0] eqb,
  output logic [DW-1:0] esign_ex_out,
  output logic          evalid
);

  logic          ewreg_q, ewreg_d;
  logic          em2reg_q, em2reg_d;
  logic          ewmem_q, ewmem_d;
  logic          ealuimm_q, ealuimm_d;
  logic [AW-1:0] ealuc_q, ealuc_d;
  logic [RW-1:0] ern_q, ern_d;
  logic [DW-1:0] eqa_q, eqa_d;
  logic [DW-1:0] eqb_q, eqb_d;
  logic [DW-1:0] esign_ex_out_q, esign_ex_out_d;
  logic          evalid_q, evalid_d;

  logic [DW-1:0] fwd_a, fwd_b;

  // Operand forwarding muxes; eqb never takes the immediate, EXE selects that via ealuimm.
  always_comb begin
    fwd_a = dqa;
    case (fwda)
      2'b00:   fwd_a = dqa;
      2'b01:   fwd_a = ealu;
      2'b10:   fwd_a = malu;
      default: fwd_a = mmo;
    endcase
  end

  always_comb begin
    fwd_b = dqb;
    case (fwdb)
      2'b00:   fwd_b = dqb;
      2'b01:   fwd_b = ealu;
      2'b10:   fwd_b = malu;
      default: fwd_b = mmo;
    endcase
  end

  always_comb begin
    ewreg_d        = ewreg_q;
    em2reg_d       = em2reg_q;
    ewmem_d        = ewmem_q;
    ealuimm_d      = ealuimm_q;
    ealuc_d        = ealuc_q;
    ern_d          = ern_q;
    eqa_d          = eqa_q;
    eqb_d          = eqb_q;
    esign_ex_out_d = esign_ex_out_q;
    evalid_d       = evalid_q;
    if (flush || (!hold && bubble)) begin
      ewreg_d        = 1'b0;
      em2reg_d       = 1'b0;
      ewmem_d        = 1'b0;
      ealuimm_d      = 1'b0;
      ealuc_d        = '0;
      ern_d          = '0;
      eqa_d          = '0;
      eqb_d          = '0;
      esign_ex_out_d = '0;
      evalid_d       = 1'b0;
    end else if (!hold) begin
      // Writes to $0 are squashed here so downstream never sees them as real writes.
      ewreg_d        = dwreg && (drn != '0);
      em2reg_d       = dm2reg;
      ewmem_d        = dwmem;
      ealuimm_d      = daluimm;
      ealuc_d        = daluc;
      ern_d          = drn;
      eqa_d          = fwd_a;
      eqb_d          = fwd_b;
      esign_ex_out_d = dsign_ex_out;
      evalid_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ewreg_q        <= 1'b0;
      em2reg_q       <= 1'b0;
      ewmem_q        <= 1'b0;
      ealuimm_q      <= 1'b0;
      ealuc_q        <= '0;
      ern_q          <= '0;
      eqa_q          <= '0;
      eqb_q          <= '0;
      esign_ex_out_q <= '0;
      evalid_q       <= 1'b0;
    end else begin
      ewreg_q        <= ewreg_d;
      em2reg_q       <= em2reg_d;
      ewmem_q        <= ewmem_d;
      ealuimm_q      <= ealuimm_d;
      ealuc_q        <= ealuc_d;
      ern_q          <= ern_d;
      eqa_q          <= eqa_d;
      eqb_q          <= eqb_d;
      esign_ex_out_q <= esign_ex_out_d;
      evalid_q       <= evalid_d;
    end
  end

  assign ewreg        = ewreg_q;
  assign em2reg       = em2reg_q;
  assign ewmem        = ewmem_q;
  assign ealuimm      = ealuimm_q;
  assign ealuc        = ealuc_q;
  assign ern          = ern_q;
  assign eqa          = eqa_q;
  assign eqb          = eqb_q;
  assign esign_ex_out = esign_ex_out_q;
  assign evalid       = evalid_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg: expected E-stage state is queued when stimulus is driven
// and popped for comparison one edge later.
module tb_id_exe_reg;

  typedef struct packed {
    logic        ewreg;
    logic        em2reg;
    logic        ewmem;
    logic        ealuimm;
    logic [3:0]  ealuc;
    logic [4:0]  ern;
    logic [31:0] eqa;
    logic [31:0] eqb;
    logic [31:0] esx;
    logic        evalid;
  } out_t;

  logic        clk = 1'b0;
  logic        rst, hold, bubble, flush;
  logic        dwreg, dm2reg, dwmem, daluimm;
  logic [3:0]  daluc;
  logic [4:0]  drn;
  logic [31:0] dqa, dqb, dsign_ex_out, ealu_in, malu, mmo;
  logic [1:0]  fwda, fwdb;
  logic        ewreg, em2reg, ewmem, ealuimm, evalid;
  logic [3:0]  ealuc;
  logic [4:0]  ern;
  logic [31:0] eqa, eqb, esign_ex_out;

  int   checks = 0;
  int   errors = 0;
  out_t mdl;
  out_t sb[$];

  always #5 clk = ~clk;

  id_exe_reg dut (
    .clk(clk), .rst(rst), .hold(hold), .bubble(bubble), .flush(flush),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm),
    .daluc(daluc), .drn(drn), .dqa(dqa), .dqb(dqb), .dsign_ex_out(dsign_ex_out),
    .fwda(fwda), .fwdb(fwdb), .ealu(ealu_in), .malu(malu), .mmo(mmo),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
    .ealuc(ealuc), .ern(ern), .eqa(eqa), .eqb(eqb), .esign_ex_out(esign_ex_out),
    .evalid(evalid)
  );

  function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] d);
    case (s)
      2'b00:   return d;
      2'b01:   return ealu_in;
      2'b10:   return malu;
      default: return mmo;
    endcase
  endfunction

  // Reference next state from the current drive and the previous model state.
  function automatic out_t next_state();
    out_t n;
    n = '0;
    if (flush) n = '0;
    else if (hold) n = mdl;
    else if (bubble) n = '0;
    else begin
      n.ewreg   = dwreg & (drn != 5'd0);
      n.em2reg  = dm2reg;
      n.ewmem   = dwmem;
      n.ealuimm = daluimm;
      n.ealuc   = daluc;
      n.ern     = drn;
      n.eqa     = fsel(fwda, dqa);
      n.eqb     = fsel(fwdb, dqb);
      n.esx     = dsign_ex_out;
      n.evalid  = 1'b1;
    end
    return n;
  endfunction

  task automatic drive(input logic h, input logic b, input logic f, input logic wr,
                       input logic m2r, input logic wm, input logic ai, input logic [3:0] ac,
                       input logic [4:0] rn, input logic [31:0] qa, input logic [31:0] qb,
                       input logic [31:0] sx, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] ea, input logic [31:0] ma, input logic [31:0] mo);
    hold = h; bubble = b; flush = f; dwreg = wr; dm2reg = m2r; dwmem = wm; daluimm = ai;
    daluc = ac; drn = rn; dqa = qa; dqb = qb; dsign_ex_out = sx; fwda = fa; fwdb = fb;
    ealu_in = ea; malu = ma; mmo = mo;
  endtask

  task automatic compare(input string tag);
    out_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty got %0d entries want 1", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks += 10;
      assert (ewreg === e.ewreg) else begin
        errors++; $error("FAIL %s ewreg got %0h want %0h", tag, ewreg, e.ewreg);
      end
      assert (em2reg === e.em2reg) else begin
        errors++; $error("FAIL %s em2reg got %0h want %0h", tag, em2reg, e.em2reg);
      end
      assert (ewmem === e.ewmem) else begin
        errors++; $error("FAIL %s ewmem got %0h want %0h", tag, ewmem, e.ewmem);
      end
      assert (ealuimm === e.ealuimm) else begin
        errors++; $error("FAIL %s ealuimm got %0h want %0h", tag, ealuimm, e.ealuimm);
      end
      assert (ealuc === e.ealuc) else begin
        errors++; $error("FAIL %s ealuc got %0h want %0h", tag, ealuc, e.ealuc);
      end
      assert (ern === e.ern) else begin
        errors++; $error("FAIL %s ern got %0h want %0h", tag, ern, e.ern);
      end
      assert (eqa === e.eqa) else begin
        errors++; $error("FAIL %s eqa got %0h want %0h", tag, eqa, e.eqa);
      end
      assert (eqb === e.eqb) else begin
        errors++; $error("FAIL %s eqb got %0h want %0h", tag, eqb, e.eqb);
      end
      assert (esign_ex_out === e.esx) else begin
        errors++; $error("FAIL %s esign_ex_out got %0h want %0h", tag, esign_ex_out, e.esx);
      end
      assert (evalid === e.evalid) else begin
        errors++; $error("FAIL %s evalid got %0h want %0h", tag, evalid, e.evalid);
      end
    end
  endtask

  // Inputs are already driven; queue the model result, take one edge, check.
  task automatic cycle(input string tag);
    mdl = next_state();
    sb.push_back(mdl);
    @(posedge clk);
    #1;
    compare(tag);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0, 0);
    mdl = '0;
    @(negedge clk);
    sb.push_back('0);
    compare("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    drive(0, 0, 0, 1, 1, 1, 1, 4'h9, 5'd3, 32'h1234, 32'h5678, 32'h9ABC, 2'b00, 2'b00,
          32'h1, 32'h2, 32'h3);
    cycle("preload_nonzero");
    // Asynchronous reset mid-cycle with nonzero outputs.
    #2 rst = 1'b1;
    #1;
    mdl = '0;
    sb.push_back('0);
    compare("reset_async");
    @(posedge clk);
    #1;
    sb.push_back('0);
    compare("reset_held_over_edge");
    @(negedge clk);
    rst = 1'b0;

    drive(0, 0, 0, 1, 0, 0, 1, 4'h2, 5'd8, 32'h11, 32'h22, 32'hFFFF_FFF0, 2'b00, 2'b00,
          32'hDEAD, 32'hBEEF, 32'hCAFE);
    cycle("load_fwd00");

    drive(0, 0, 0, 1, 0, 0, 0, 4'h3, 5'd9, 32'h100, 32'h200, 32'h4, 2'b01, 2'b11,
          32'hA5, 32'h77, 32'h5A);
    cycle("fwd_a01_b11");

    drive(0, 0, 0, 0, 1, 0, 0, 4'h4, 5'd10, 32'h300, 32'h400, 32'h8, 2'b10, 2'b10,
          32'hA5, 32'h77, 32'h5A);
    cycle("fwd_a10_b10");

    drive(0, 0, 0, 0, 0, 1, 1, 4'hF, 5'd31, 32'h500, 32'h600, 32'hC, 2'b11, 2'b01,
          32'h1111, 32'h2222, 32'h3333);
    cycle("fwd_a11_b01");

    drive(0, 1, 0, 1, 1, 1, 1, 4'h5, 5'd12, 32'h700, 32'h800, 32'h10, 2'b00, 2'b00,
          32'h0, 32'h0, 32'h0);
    cycle("bubble");

    drive(0, 0, 0, 1, 0, 1, 0, 4'h6, 5'd13, 32'h900, 32'hA00, 32'h14, 2'b00, 2'b00,
          32'h0, 32'h0, 32'h0);
    cycle("load_after_bubble");

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, i[0], 1, 1, 1, 4'(i + 7), 5'(i + 20), 32'(i * 3 + 1), 32'(i * 5 + 2),
            32'(i), 2'(i), 2'(i + 1), 32'hF0F0, 32'h0F0F, 32'hFFFF);
      cycle("hold");
    end

    drive(1, 1, 0, 1, 1, 1, 1, 4'hA, 5'd5, 32'h1, 32'h2, 32'h3, 2'b00, 2'b00, 0, 0, 0);
    cycle("hold_over_bubble");

    drive(1, 0, 1, 1, 1, 1, 1, 4'hB, 5'd6, 32'h4, 32'h5, 32'h6, 2'b00, 2'b00, 0, 0, 0);
    cycle("hold_and_flush");

    drive(0, 0, 0, 1, 1, 0, 1, 4'hC, 5'd7, 32'h44, 32'h55, 32'h66, 2'b00, 2'b00, 0, 0, 0);
    cycle("reload");

    drive(0, 0, 1, 1, 1, 1, 1, 4'hD, 5'd8, 32'h7, 32'h8, 32'h9, 2'b01, 2'b01, 32'h9, 0, 0);
    cycle("flush");

    drive(0, 0, 0, 1, 0, 0, 0, 4'h1, 5'd0, 32'hAB, 32'hCD, 32'hEF, 2'b00, 2'b00, 0, 0, 0);
    cycle("r0_write");

    // Reset asserted during a hold must still clear.
    drive(0, 0, 0, 1, 1, 1, 1, 4'h8, 5'd17, 32'h77, 32'h88, 32'h99, 2'b00, 2'b00, 0, 0, 0);
    cycle("preload_for_hold_rst");
    hold = 1'b1;
    #2 rst = 1'b1;
    #1;
    mdl = '0;
    sb.push_back('0);
    compare("reset_during_hold");
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 0, 4'h2, 5'd4, 32'h3C, 32'h4D, 32'h5E, 2'b00, 2'b00, 0, 0, 0);
    cycle("first_load_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
